// File: rtl/jt12_timer_ctrl.sv
// Register-side controller for the FM timer pair: decodes writes to 0x24-0x27,
// drives timer config, write-busy status and the ch3 CSM key-on (built only with JT12_CSM_EN).
module jt12_timer_ctrl #(
  parameter int BUSY_CNT = 32,
  parameter int CSM_LEN  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       zero,
  input  logic       wr,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  input  logic       overflow_A,
  output logic [9:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       enable_irq_A,
  output logic       enable_irq_B,
  output logic       clr_flag_A,
  output logic       clr_flag_B,
  output logic [1:0] ch3_mode,
  output logic       csm_kon,
  output logic       busy
);

  localparam logic [5:0] BUSY_LD = 6'(BUSY_CNT);

  logic [5:0] busy_cnt;

  // Register file; clear bits only produce a one-clk pulse and are not stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_A      <= '0;
      value_B      <= '0;
      load_A       <= 1'b0;
      load_B       <= 1'b0;
      enable_irq_A <= 1'b0;
      enable_irq_B <= 1'b0;
      clr_flag_A   <= 1'b0;
      clr_flag_B   <= 1'b0;
      ch3_mode     <= '0;
    end else begin
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
      if (wr) begin
        case (addr)
          8'h24: value_A[9:2] <= din;
          8'h25: value_A[1:0] <= din[1:0];
          8'h26: value_B      <= din;
          8'h27: begin
            ch3_mode     <= din[7:6];
            clr_flag_B   <= din[5];
            clr_flag_A   <= din[4];
            enable_irq_B <= din[3];
            enable_irq_A <= din[2];
            load_B       <= din[1];
            load_A       <= din[0];
          end
          default: ;
        endcase
      end
    end
  end

  // Any write (even to an unmapped address) reloads the busy window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy_cnt <= '0;
    else if (wr)
      busy_cnt <= BUSY_LD;
    else if (cen && busy_cnt != 6'd0)
      busy_cnt <= busy_cnt - 6'd1;
  end

  assign busy = (busy_cnt != 6'd0);

`ifdef JT12_CSM_EN
  typedef enum logic [1:0] {
    CSM_IDLE = 2'd0,
    CSM_ON   = 2'd1,
    CSM_OFF  = 2'd2
  } csm_state_t;

  localparam logic [7:0] CSM_LD = 8'(CSM_LEN);

  csm_state_t csm_state, csm_next;
  logic [7:0] frame_cnt, frame_next;
  logic       frame_tick;

  assign frame_tick = cen & zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csm_state <= CSM_IDLE;
      frame_cnt <= '0;
    end else begin
      csm_state <= csm_next;
      frame_cnt <= frame_next;
    end
  end

  // The OFF state holds key-off for one frame so the envelope always sees it.
  always_comb begin
    csm_next   = csm_state;
    frame_next = frame_cnt;
    if (!ch3_mode[1]) begin
      csm_next = CSM_IDLE;
    end else begin
      case (csm_state)
        CSM_IDLE: if (frame_tick && overflow_A) begin
          csm_next   = CSM_ON;
          frame_next = CSM_LD;
        end
        CSM_ON: if (frame_tick) begin
          if (frame_cnt != 8'd0) frame_next = frame_cnt - 8'd1;
          if (frame_cnt <= 8'd1) csm_next = CSM_OFF;
        end
        CSM_OFF: if (frame_tick) csm_next = CSM_IDLE;
        default: csm_next = CSM_IDLE;
      endcase
    end
  end

  // Gating with ch3_mode drops key-on as soon as CSM mode is written off.
  assign csm_kon = (csm_state == CSM_ON) && ch3_mode[1];
`else
  logic unused_csm;
  assign unused_csm = overflow_A ^ zero;
  assign csm_kon    = 1'b0;
`endif

endmodule

// File: tb/tb_jt12_timer_ctrl.sv
// Self-checking bench for jt12_timer_ctrl: register map, flag-clear pulses,
// busy window and (when JT12_CSM_EN is defined) the CSM key-on sequence.
module tb_jt12_timer_ctrl;

`ifdef JT12_CSM_EN
  localparam logic HAS_CSM = 1'b1;
`else
  localparam logic HAS_CSM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0, zero = 1'b0, wr = 1'b0, overflow_A = 1'b0;
  logic [7:0] addr = '0, din = '0;
  logic [9:0] value_A;
  logic [7:0] value_B;
  logic       load_A, load_B, enable_irq_A, enable_irq_B;
  logic       clr_flag_A, clr_flag_B, csm_kon, busy;
  logic [1:0] ch3_mode;

  jt12_timer_ctrl #(.BUSY_CNT(32), .CSM_LEN(1)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero), .wr(wr),
    .addr(addr), .din(din), .overflow_A(overflow_A),
    .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
    .enable_irq_A(enable_irq_A), .enable_irq_B(enable_irq_B),
    .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B),
    .ch3_mode(ch3_mode), .csm_kon(csm_kon), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [23:0] regs_obs;
  assign regs_obs = {value_A, value_B, ch3_mode, enable_irq_B, enable_irq_A, load_B, load_A};

  int n_vec = 0;
  int n_err = 0;
  logic [23:0] exp_q[$];

  logic [9:0] m_va;
  logic [7:0] m_vb;
  logic [1:0] m_mode;
  logic [3:0] m_ctl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_va = '0; m_vb = '0; m_mode = '0; m_ctl = '0;
  endtask

  // driver: one clk of stimulus, returns just after the active edge
  task automatic cycle(input logic c, input logic z, input logic w,
                       input logic [7:0] a, input logic [7:0] d, input logic ov);
    @(negedge clk);
    cen = c; zero = z; wr = w; addr = a; din = d; overflow_A = ov;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic frame(input logic ov);
    cycle(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, ov);
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    logic [1:0] exp_clr;
    case (a)
      8'h24: m_va[9:2] = d;
      8'h25: m_va[1:0] = d[1:0];
      8'h26: m_vb = d;
      8'h27: begin m_mode = d[7:6]; m_ctl = d[3:0]; end
      default: ;
    endcase
    exp_q.push_back({m_va, m_vb, m_mode, m_ctl});
    exp_clr = (a == 8'h27) ? {d[5], d[4]} : 2'b00;
    cycle(1'b0, 1'b0, 1'b1, a, d, 1'b0);
    check("regs", regs_obs, exp_q.pop_front());
    check("clr_pulse", {clr_flag_B, clr_flag_A}, exp_clr);
    check("busy_after_wr", busy, 1'b1);
  endtask

  task automatic cen_strobes(input int n, input int last_busy_idx);
    for (int i = 1; i <= n; i++) begin
      idle();
      repeat ($urandom_range(0, 2)) idle();
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      check("busy_strobe", busy, (i < last_busy_idx) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_regs", regs_obs, 24'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_flags", {clr_flag_B, clr_flag_A, csm_kon}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // register map
    write_reg(8'h24, 8'hAB);
    write_reg(8'h25, 8'h03);
    check("value_A_2AF", value_A, 10'h2AF);
    write_reg(8'h26, 8'h5C);
    check("value_B_5C", value_B, 8'h5C);
    write_reg(8'h27, 8'h3F);
    check("ctl_3F", {load_A, load_B, enable_irq_A, enable_irq_B, ch3_mode}, 6'b1111_00);
    idle();
    check("clr_end", {clr_flag_B, clr_flag_A}, 2'b00);
    write_reg(8'h27, 8'h30);
    write_reg(8'h27, 8'h10);
    idle();
    check("clr_b2b_end", {clr_flag_B, clr_flag_A}, 2'b00);

    for (int i = 0; i < 8; i++)
      write_reg(8'h24 + 8'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    idle();
    check("clr_rand_end", {clr_flag_B, clr_flag_A}, 2'b00);

    // busy window, including a rewrite while busy
    write_reg(8'h30, 8'hFF);
    cen_strobes(32, 32);
    write_reg(8'h31, 8'h00);
    cen_strobes(20, 99);
    write_reg(8'h30, 8'h55);
    cen_strobes(32, 32);

    // CSM key-on sequence
    write_reg(8'h27, 8'h80);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    check("kon_cen_only", csm_kon, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    check("kon_zero_only", csm_kon, 1'b0);
    frame(1'b1);
    check("kon_rise", csm_kon, HAS_CSM);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    check("kon_hold", csm_kon, HAS_CSM);
    frame(1'b1);
    check("kon_off", csm_kon, 1'b0);
    frame(1'b1);
    check("kon_off_ign", csm_kon, 1'b0);
    frame(1'b1);
    check("kon_retrig", csm_kon, HAS_CSM);
    write_reg(8'h27, 8'h00);
    check("kon_mode_clr", csm_kon, 1'b0);
    frame(1'b1);
    check("kon_mode00", csm_kon, 1'b0);
    write_reg(8'h27, 8'hC0);
    frame(1'b1);
    check("kon_mode11", csm_kon, HAS_CSM);
    write_reg(8'h24, 8'h77);
    check("kon_pre_rst", csm_kon, HAS_CSM);

    // asynchronous reset mid-busy and mid-ON
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_regs", regs_obs, {m_va, m_vb, m_mode, m_ctl});
    check("arst_busy", busy, 1'b0);
    check("arst_kon", csm_kon, 1'b0);
    frame(1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_kon", csm_kon, 1'b0);
    check("post_rst_regs", regs_obs, 24'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
